head_table_wr_arb: RTL and testbench
====================================

# head_table_wr_arb

Write-port arbiter and sequencer for the bucket head-pointer RAM. It shares the single head-table write port between `N_REQ` requesters, such as the insert and delete engines, using round-robin arbitration. It also owns the clear sweep that zeroes every bucket. It sits between the update engines and the head table's write interface (`wr_en`/`wr_addr`/`wr_data_ptr`/`wr_data_ptr_val`).

## Interface
- `BUCKET_WIDTH`, 8, head RAM address width; depth is 2^BUCKET_WIDTH
- `HEAD_PTR_WIDTH`, 10, width of the head pointer
- `N_REQ`, 2, number of write requesters (2..8)
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset: asynchronous, active-high
- `req_valid_i`  in  N_REQ  per-requester write request
- `req_bucket_i`  in  N_REQ*BUCKET_WIDTH  target bucket; requester k occupies slice k
- `req_ptr_i`  in  N_REQ*HEAD_PTR_WIDTH  new head pointer
- `req_ptr_val_i`  in  N_REQ  new head-pointer valid flag
- `req_ready_o`  out  N_REQ  one-hot grant; a transfer happens when valid && ready
- `clear_run_i`  in  1  single-cycle pulse that starts the clear sweep
- `clear_done_o`  out  1  single-cycle pulse marking the final clear write
- `busy_o`  out  1  high while the sweep is in progress
- `ht_wr_en_o`  out  1  head-table write enable
- `ht_wr_addr_o`  out  BUCKET_WIDTH  head-table write address
- `ht_wr_ptr_o`  out  HEAD_PTR_WIDTH  head-table write pointer
- `ht_wr_ptr_val_o`  out  1  head-table write valid flag

## Operation
- FSM has two states: IDLE and CLEAR.
- **IDLE:**
  - Arbitrate among asserted `req_valid_i`.
  - Grant the first valid requester after `last_grant`, wrapping from N_REQ-1 to 0.
  - `last_grant` updates only on a transfer.
- **CLEAR:**
  - Every `req_ready_o` is 0.
  - A counter `clr_addr` runs 0..2^BUCKET_WIDTH-1, issuing one zero write per cycle (ptr=0, ptr_val=0).
  - After the all-ones address is issued, return to IDLE.
- **clear_run_i in IDLE:** move to CLEAR with `clr_addr`=0. There is no grant in that cycle, even if requests are valid.
- **clear_run_i in CLEAR:** restart the sweep, with `clr_addr`=0 in the next cycle.
- **Requester rules:**
  - A requester holds `req_valid_i` and its data stable until ready.
  - `req_valid_i` must not depend on `req_ready_o`.
  - `req_ready_o` may depend combinationally on `req_valid_i`.
- **Ready outputs:**
  - `req_ready_o` is one-hot or zero.
  - It is never asserted for a requester whose `req_valid_i` is low.
- **Reset values:**
  - All outputs are 0.
  - FSM is IDLE, `clr_addr` is 0.
  - `last_grant` is N_REQ-1, so requester 0 wins first.
- Reset asserted mid-sweep aborts it: no `clear_done_o` pulse, and the FSM returns to IDLE.

## Timing
- `ht_wr_*` outputs are registered.
- **Write latency:** a handshake in cycle t drives `ht_wr_en_o`=1 with that request's data in cycle t+1.
- **Clear write latency:**
  - The clear write for address a, issued in cycle t, appears in cycle t+1.
  - `clear_done_o` is high in the same cycle `ht_wr_addr_o`=all-ones, with `ht_wr_en_o`=1 and clear data.
- **Throughput:** one write per cycle, with no bubbles between back-to-back grants.
- **Sweep duration:** the sweep occupies exactly 2^BUCKET_WIDTH cycles of writes.
- **busy_o:**
  - High from the cycle after the `clear_run_i` pulse through the cycle of `clear_done_o`.
  - High again from the cycle after an IDLE→CLEAR decision.
- `ht_wr_en_o` is 0 in any cycle following one with no transfer and no clear write.

## Configuration
- `HEAD_WR_ARB_FIXED_PRIO_EN`:
  - **Defined:** fixed priority, where the lowest index wins; `last_grant` is not implemented.
  - **Undefined:** round-robin as above.
- Clear-sweep behaviour is identical either way.

## Structure
- `head_table_pkg` holds:
  - the `head_ram_data_t` struct {ptr, ptr_val}, shared with the head table;
  - the FSM enum `head_wr_arb_state_t` {IDLE, CLEAR}.
- Sub-module `rr_arbiter`, parameterised by N:
  - `req`/`gnt` one-hot plus an `advance` input;
  - holds `last_grant`;
  - contains the fixed-priority path under the macro.
- The top level instantiates `rr_arbiter`, owns the FSM, the clear counter and the output registers.

## Test plan
- **Single request:** req 0 valid with bucket=0x12, ptr=0x155, val=1.
  - Expect `req_ready_o`=01.
  - Next cycle: wr_en=1, addr=0x12, ptr=0x155, val=1.
- **Round-robin:** req 0 and req 1 both held valid for 4 cycles.
  - Expect grants 0,1,0,1, with 4 consecutive wr_en cycles.
  - With the macro defined: grants 0,0,0,0.
- **Full clear:** `clear_run_i` pulse with BUCKET_WIDTH=4.
  - Expect 16 writes, addr 0..15 with zero data.
  - `clear_done_o` pulses with addr=15.
  - `busy_o` is high for 16 cycles.
- **Requests during clear:** req 1 valid throughout the sweep.
  - `ready` stays 0 until the cycle after `clear_done_o`.
  - Its write appears on the second cycle after `clear_done_o`.
- **Clear restart:** `clear_run_i` re-pulsed when `clr_addr`=5.
  - Next write address is 0.
  - `clear_done_o` fires only once, after 0..15 complete.
- **Reset mid-sweep:** assert `rst_i` at address 7.
  - All outputs go 0 immediately.
  - No `clear_done_o`.
  - After release, req 0 is granted first.

Source files
------------

// File: rtl/head_table_pkg.sv
// head_table_pkg: types shared by the head table and its write-port arbiter.
// The head-RAM payload struct and the write-arbiter FSM encoding live here.
package head_table_pkg;

    // Width of the head pointer stored in each bucket entry.
    localparam int unsigned HT_PTR_W = 10;

    // One head-RAM word: pointer plus its valid flag.
    typedef struct packed {
        logic [HT_PTR_W-1:0] ptr;
        logic                ptr_val;
    } head_ram_data_t;

    // Write-arbiter sequencer states.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } head_wr_arb_state_t;

endpackage : head_table_pkg

// File: rtl/head_table_wr_arb_rr_arbiter.sv
// rr_arbiter: N-way grant generator for the head-table write port.
// Default build: round-robin starting after last_grant, which moves only when
// advance_i reports a completed transfer.
// Macro HEAD_WR_ARB_FIXED_PRIO_EN: fixed priority, lowest index wins, and no
// grant history is kept.
module rr_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    input  logic         advance_i,
    output logic [N-1:0] gnt_c
);

`ifdef HEAD_WR_ARB_FIXED_PRIO_EN

    logic found_c;
    logic unused_c;

    // Clock, reset and advance have no role without grant history.
    assign unused_c = ^{clk_i, rst_i, advance_i};

    // Lowest-index valid requester wins.
    always_comb begin
        gnt_c   = '0;
        found_c = 1'b0;
        for (int unsigned j = 0; j < N; j++) begin
            if (!found_c && req_i[j]) begin
                gnt_c[j] = 1'b1;
                found_c  = 1'b1;
            end
        end
    end

`else

    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] last_grant_q;
    logic [IDX_W-1:0] last_grant_d;
    logic             found_c;

    // Search from last_grant+1 upward with wrap; first valid requester wins.
    always_comb begin
        gnt_c   = '0;
        found_c = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (!found_c && req_i[j] && (j == ((32'(last_grant_q) + i) % N))) begin
                    gnt_c[j] = 1'b1;
                    found_c  = 1'b1;
                end
            end
        end
    end

    // Remember the granted index only when the grant turned into a transfer.
    always_comb begin
        last_grant_d = last_grant_q;
        if (advance_i) begin
            for (int unsigned j = 0; j < N; j++) begin
                if (gnt_c[j]) begin
                    last_grant_d = IDX_W'(j);
                end
            end
        end
    end

    // Grant history register; resets to N-1 so requester 0 is favoured first.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_grant_q <= IDX_W'(N - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

`endif

endmodule : rr_arbiter

// File: rtl/head_table_wr_arb.sv
// head_table_wr_arb: shares the head-table write port between N_REQ update
// engines and runs the clear sweep that zeroes every bucket.
// Optional macro HEAD_WR_ARB_FIXED_PRIO_EN selects fixed-priority arbitration
// (lowest index wins) instead of round-robin; the sweep is unaffected.
// Note: the stored pointer width is head_table_pkg::HT_PTR_W; HEAD_PTR_WIDTH is
// expected to match it.
module head_table_wr_arb
    import head_table_pkg::*;
#(
    parameter int unsigned BUCKET_WIDTH   = 8,
    parameter int unsigned HEAD_PTR_WIDTH = 10,
    parameter int unsigned N_REQ          = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [N_REQ-1:0]                 req_valid_i,
    input  logic [N_REQ*BUCKET_WIDTH-1:0]    req_bucket_i,
    input  logic [N_REQ*HEAD_PTR_WIDTH-1:0]  req_ptr_i,
    input  logic [N_REQ-1:0]                 req_ptr_val_i,
    output logic [N_REQ-1:0]                 req_ready_o,
    input  logic                             clear_run_i,
    output logic                             clear_done_o,
    output logic                             busy_o,
    output logic                             ht_wr_en_o,
    output logic [BUCKET_WIDTH-1:0]          ht_wr_addr_o,
    output logic [HEAD_PTR_WIDTH-1:0]        ht_wr_ptr_o,
    output logic                             ht_wr_ptr_val_o
);

    localparam logic [BUCKET_WIDTH-1:0] LAST_ADDR = '1;

    head_wr_arb_state_t        state_q, state_d;
    logic [BUCKET_WIDTH-1:0]   clr_addr_q, clr_addr_d;
    logic                      wr_en_q, wr_en_d;
    logic [BUCKET_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    head_ram_data_t            wr_data_q, wr_data_d;
    logic                      clear_done_q, clear_done_d;
    logic                      busy_q, busy_d;

    logic [N_REQ-1:0]          gnt_c;
    logic [N_REQ-1:0]          ready_c;
    logic                      xfer_c;
    logic [BUCKET_WIDTH-1:0]   sel_bucket_c;
    logic [HEAD_PTR_WIDTH-1:0] sel_ptr_c;
    logic                      sel_ptr_val_c;
    logic                      clr_wr_c;
    logic [BUCKET_WIDTH-1:0]   clr_next_c;

    // Grant generator; history advances on every completed handshake.
    rr_arbiter #(
        .N (N_REQ)
    ) u_rr_arbiter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (req_valid_i),
        .advance_i (xfer_c),
        .gnt_c     (gnt_c)
    );

    // Grants only in IDLE, never in a clear-start cycle, never during reset.
    always_comb begin
        ready_c = '0;
        if (!rst_i && (state_q == IDLE) && !clear_run_i) begin
            ready_c = gnt_c;
        end
    end

    assign req_ready_o = ready_c;
    assign xfer_c      = |ready_c;

    // Select the granted requester's payload.
    always_comb begin
        sel_bucket_c  = '0;
        sel_ptr_c     = '0;
        sel_ptr_val_c = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (ready_c[k]) begin
                sel_bucket_c  = req_bucket_i[k*BUCKET_WIDTH +: BUCKET_WIDTH];
                sel_ptr_c     = req_ptr_i[k*HEAD_PTR_WIDTH +: HEAD_PTR_WIDTH];
                sel_ptr_val_c = req_ptr_val_i[k];
            end
        end
    end

    // Next-state and write-port decode. clr_addr tracks the address of the
    // clear write currently on the port, so the sweep ends on the cycle that
    // presents the all-ones address and IDLE resumes one cycle later.
    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        clear_done_d = 1'b0;
        busy_d       = 1'b0;
        clr_wr_c     = 1'b0;
        clr_next_c   = '0;

        case (state_q)
            IDLE: begin
                if (clear_run_i) begin
                    clr_wr_c = 1'b1;
                    state_d  = CLEAR;
                end else if (xfer_c) begin
                    wr_en_d           = 1'b1;
                    wr_addr_d         = sel_bucket_c;
                    wr_data_d.ptr     = HT_PTR_W'(sel_ptr_c);
                    wr_data_d.ptr_val = sel_ptr_val_c;
                end
            end
            CLEAR: begin
                if (clear_run_i) begin
                    clr_wr_c = 1'b1;
                end else if (clr_addr_q != LAST_ADDR) begin
                    clr_wr_c   = 1'b1;
                    clr_next_c = clr_addr_q + 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (clr_wr_c) begin
            wr_en_d      = 1'b1;
            wr_addr_d    = clr_next_c;
            wr_data_d    = '0;
            clr_addr_d   = clr_next_c;
            clear_done_d = (clr_next_c == LAST_ADDR);
        end

        busy_d = (state_d == CLEAR);
    end

    // State, sweep counter and registered write-port outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            clr_addr_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            clear_done_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            clear_done_q <= clear_done_d;
            busy_q       <= busy_d;
        end
    end

    assign ht_wr_en_o      = wr_en_q;
    assign ht_wr_addr_o    = wr_addr_q;
    assign ht_wr_ptr_o     = HEAD_PTR_WIDTH'(wr_data_q.ptr);
    assign ht_wr_ptr_val_o = wr_data_q.ptr_val;
    assign clear_done_o    = clear_done_q;
    assign busy_o          = busy_q;

endmodule : head_table_wr_arb

// File: tb/tb_head_table_wr_arb.sv
// Bench for head_table_wr_arb with BUCKET_WIDTH=4, N_REQ=2.
// Table of single-cycle handshake vectors plus hand-written clear sequences.
module tb_head_table_wr_arb;

    localparam int unsigned BW = 4;
    localparam int unsigned PW = 10;
    localparam int unsigned N  = 2;
`ifdef HEAD_WR_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic [N-1:0]    req_valid_i;
    logic [N*BW-1:0] req_bucket_i;
    logic [N*PW-1:0] req_ptr_i;
    logic [N-1:0]    req_ptr_val_i;
    logic [N-1:0]    req_ready_o;
    logic            clear_run_i;
    logic            clear_done_o;
    logic            busy_o;
    logic            ht_wr_en_o;
    logic [BW-1:0]   ht_wr_addr_o;
    logic [PW-1:0]   ht_wr_ptr_o;
    logic            ht_wr_ptr_val_o;

    head_table_wr_arb #(
        .BUCKET_WIDTH   (BW),
        .HEAD_PTR_WIDTH (PW),
        .N_REQ          (N)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .req_valid_i     (req_valid_i),
        .req_bucket_i    (req_bucket_i),
        .req_ptr_i       (req_ptr_i),
        .req_ptr_val_i   (req_ptr_val_i),
        .req_ready_o     (req_ready_o),
        .clear_run_i     (clear_run_i),
        .clear_done_o    (clear_done_o),
        .busy_o          (busy_o),
        .ht_wr_en_o      (ht_wr_en_o),
        .ht_wr_addr_o    (ht_wr_addr_o),
        .ht_wr_ptr_o     (ht_wr_ptr_o),
        .ht_wr_ptr_val_o (ht_wr_ptr_val_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0] valid;
        logic [3:0] b0;
        logic [9:0] p0;
        logic [3:0] b1;
        logic [9:0] p1;
        logic [1:0] pv;
        logic [1:0] exp_rdy;
        logic       exp_en;
        logic [3:0] exp_addr;
        logic [9:0] exp_ptr;
        logic       exp_pv;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs[NV];

    int tests  = 0;
    int failed = 0;
    int done_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_req(input logic [1:0] v, input logic [3:0] b0, input logic [9:0] p0,
                           input logic [3:0] b1, input logic [9:0] p1, input logic [1:0] pv);
        req_valid_i   = v;
        req_bucket_i  = {b1, b0};
        req_ptr_i     = {p1, p0};
        req_ptr_val_i = pv;
    endtask

    function automatic vec_t mkv(input logic [1:0] v, input logic [3:0] b0, input logic [9:0] p0,
                                 input logic [3:0] b1, input logic [9:0] p1, input logic [1:0] pv,
                                 input logic [1:0] rdy, input logic en, input logic [3:0] addr,
                                 input logic [9:0] ptr, input logic pval);
        vec_t r;
        r.valid = v;   r.b0 = b0;      r.p0 = p0;     r.b1 = b1;       r.p1 = p1;  r.pv = pv;
        r.exp_rdy = rdy; r.exp_en = en; r.exp_addr = addr; r.exp_ptr = ptr; r.exp_pv = pval;
        return r;
    endfunction

    initial begin
        bit g1;

        // Vector table: after reset last_grant=1, so requester 0 wins first.
        vecs[0] = mkv(2'b01, 4'hC, 10'h155, 4'h0, 10'h000, 2'b01, 2'b01, 1'b1, 4'hC, 10'h155, 1'b1);
        vecs[1] = mkv(2'b00, 4'h0, 10'h000, 4'h0, 10'h000, 2'b00, 2'b00, 1'b0, 4'h0, 10'h000, 1'b0);
        vecs[2] = mkv(2'b10, 4'h0, 10'h000, 4'h5, 10'h2AA, 2'b10, 2'b10, 1'b1, 4'h5, 10'h2AA, 1'b1);
        for (int k = 0; k < 4; k++) begin
            g1 = !FIXED && ((k % 2) == 1);
            vecs[3+k] = mkv(2'b11, 4'h3, 10'h0A1, 4'hE, 10'h3FF, 2'b01,
                            g1 ? 2'b10 : 2'b01, 1'b1, g1 ? 4'hE : 4'h3,
                            g1 ? 10'h3FF : 10'h0A1, g1 ? 1'b0 : 1'b1);
        end
        vecs[7] = mkv(2'b00, 4'h0, 10'h000, 4'h0, 10'h000, 2'b00, 2'b00, 1'b0, 4'h0, 10'h000, 1'b0);
        vecs[8] = mkv(2'b10, 4'h0, 10'h000, 4'h9, 10'h001, 2'b10, 2'b10, 1'b1, 4'h9, 10'h001, 1'b1);

        // Reset state.
        rst_i       = 1'b1;
        clear_run_i = 1'b0;
        set_req(2'b00, 4'h0, 10'h0, 4'h0, 10'h0, 2'b00);
        repeat (2) @(negedge clk_i);
        #1;
        chk("rst wr_en", 32'(ht_wr_en_o), 32'd0);
        chk("rst addr", 32'(ht_wr_addr_o), 32'd0);
        chk("rst ptr", 32'(ht_wr_ptr_o), 32'd0);
        chk("rst ptr_val", 32'(ht_wr_ptr_val_o), 32'd0);
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst done", 32'(clear_done_o), 32'd0);
        chk("rst ready", 32'(req_ready_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Table-driven handshakes, including back-to-back round-robin grants.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk_i);
            set_req(vecs[i].valid, vecs[i].b0, vecs[i].p0, vecs[i].b1, vecs[i].p1, vecs[i].pv);
            #1;
            chk($sformatf("vec%0d ready", i), 32'(req_ready_o), 32'(vecs[i].exp_rdy));
            @(posedge clk_i);
            #1;
            chk($sformatf("vec%0d wr_en", i), 32'(ht_wr_en_o), 32'(vecs[i].exp_en));
            if (vecs[i].exp_en) begin
                chk($sformatf("vec%0d addr", i), 32'(ht_wr_addr_o), 32'(vecs[i].exp_addr));
                chk($sformatf("vec%0d ptr", i), 32'(ht_wr_ptr_o), 32'(vecs[i].exp_ptr));
                chk($sformatf("vec%0d ptr_val", i), 32'(ht_wr_ptr_val_o), 32'(vecs[i].exp_pv));
            end
        end

        // Full sweep with requester 1 waiting throughout.
        @(negedge clk_i);
        set_req(2'b10, 4'h0, 10'h000, 4'h7, 10'h123, 2'b10);
        clear_run_i = 1'b1;
        #1;
        chk("clr pulse ready", 32'(req_ready_o), 32'd0);
        for (int a = 0; a < 16; a++) begin
            @(negedge clk_i);
            clear_run_i = 1'b0;
            #1;
            chk($sformatf("clr%0d wr_en", a), 32'(ht_wr_en_o), 32'd1);
            chk($sformatf("clr%0d addr", a), 32'(ht_wr_addr_o), 32'(a));
            chk($sformatf("clr%0d ptr", a), 32'(ht_wr_ptr_o), 32'd0);
            chk($sformatf("clr%0d ptr_val", a), 32'(ht_wr_ptr_val_o), 32'd0);
            chk($sformatf("clr%0d busy", a), 32'(busy_o), 32'd1);
            chk($sformatf("clr%0d done", a), 32'(clear_done_o), (a == 15) ? 32'd1 : 32'd0);
            chk($sformatf("clr%0d ready", a), 32'(req_ready_o), 32'd0);
        end
        @(negedge clk_i);
        #1;
        chk("post-clr busy", 32'(busy_o), 32'd0);
        chk("post-clr wr_en", 32'(ht_wr_en_o), 32'd0);
        chk("post-clr done", 32'(clear_done_o), 32'd0);
        chk("post-clr ready", 32'(req_ready_o), 32'b10);
        @(negedge clk_i);
        set_req(2'b00, 4'h0, 10'h0, 4'h0, 10'h0, 2'b00);
        #1;
        chk("post-clr req wr_en", 32'(ht_wr_en_o), 32'd1);
        chk("post-clr req addr", 32'(ht_wr_addr_o), 32'h7);
        chk("post-clr req ptr", 32'(ht_wr_ptr_o), 32'h123);
        chk("post-clr req ptr_val", 32'(ht_wr_ptr_val_o), 32'd1);

        // Sweep restarted while address 5 is on the port.
        done_cnt = 0;
        @(negedge clk_i);
        clear_run_i = 1'b1;
        for (int a = 0; a < 6; a++) begin
            @(negedge clk_i);
            clear_run_i = 1'b0;
            #1;
            chk($sformatf("rs pre%0d addr", a), 32'(ht_wr_addr_o), 32'(a));
            if (clear_done_o) done_cnt++;
        end
        clear_run_i = 1'b1;
        for (int a = 0; a < 16; a++) begin
            @(negedge clk_i);
            clear_run_i = 1'b0;
            #1;
            chk($sformatf("rs%0d wr_en", a), 32'(ht_wr_en_o), 32'd1);
            chk($sformatf("rs%0d addr", a), 32'(ht_wr_addr_o), 32'(a));
            chk($sformatf("rs%0d done", a), 32'(clear_done_o), (a == 15) ? 32'd1 : 32'd0);
            if (clear_done_o) done_cnt++;
        end
        repeat (3) begin
            @(negedge clk_i);
            #1;
            if (clear_done_o) done_cnt++;
        end
        chk("rs done pulses", 32'(done_cnt), 32'd1);
        chk("rs busy end", 32'(busy_o), 32'd0);

        // Reset asserted while address 7 is on the port.
        @(negedge clk_i);
        clear_run_i = 1'b1;
        for (int a = 0; a < 8; a++) begin
            @(negedge clk_i);
            clear_run_i = 1'b0;
            #1;
            chk($sformatf("mr%0d addr", a), 32'(ht_wr_addr_o), 32'(a));
        end
        set_req(2'b11, 4'h1, 10'h0F0, 4'h2, 10'h00F, 2'b11);
        rst_i = 1'b1;
        #1;
        chk("mr wr_en", 32'(ht_wr_en_o), 32'd0);
        chk("mr addr", 32'(ht_wr_addr_o), 32'd0);
        chk("mr ptr", 32'(ht_wr_ptr_o), 32'd0);
        chk("mr ptr_val", 32'(ht_wr_ptr_val_o), 32'd0);
        chk("mr busy", 32'(busy_o), 32'd0);
        chk("mr done", 32'(clear_done_o), 32'd0);
        chk("mr ready", 32'(req_ready_o), 32'd0);
        done_cnt = 0;
        repeat (2) begin
            @(negedge clk_i);
            #1;
            if (clear_done_o) done_cnt++;
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk("mr first grant", 32'(req_ready_o), 32'b01);
        @(negedge clk_i);
        set_req(2'b00, 4'h0, 10'h0, 4'h0, 10'h0, 2'b00);
        #1;
        if (clear_done_o) done_cnt++;
        chk("mr no done", 32'(done_cnt), 32'd0);
        chk("mr req wr_en", 32'(ht_wr_en_o), 32'd1);
        chk("mr req addr", 32'(ht_wr_addr_o), 32'h1);
        chk("mr req ptr", 32'(ht_wr_ptr_o), 32'h0F0);
        chk("mr busy after", 32'(busy_o), 32'd0);
        @(negedge clk_i);
        #1;
        chk("idle wr_en", 32'(ht_wr_en_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_head_table_wr_arb
